// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Time-shares one external combinational 16-bit ALU between two requesters.
// A single operation is accepted over a valid/ready request channel, held on
// the ALU inputs for one full ISSUE cycle, captured into a result register and
// returned to the owning requester over its valid/ready response channel.
// When both requesters are pending in IDLE, grants alternate round-robin.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready     request handshake for requester N (N=0,1)
//   reqN_code/_a/_b/_coe        opcode, operands, carry-out enable (active-low)
//   rspN_valid / rspN_ready     response handshake for requester N
//   rspN_c/_vout/_cout/_err     result, overflow, carry-out, illegal-opcode flag
//   alu_a/_b/_code/_coe         operand register driven to the ALU
//   alu_c/_vout/_cout           combinational ALU result and flags
//   busy                        high while an operation is in flight
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4:0]       req0_code,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_coe,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4:0]       req1_code,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_coe,

   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_c,
   output logic             rsp0_vout,
   output logic             rsp0_cout,
   output logic             rsp0_err,

   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_c,
   output logic             rsp1_vout,
   output logic             rsp1_cout,
   output logic             rsp1_err,

   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [4:0]       alu_code,
   output logic             alu_coe,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_vout,
   input  logic             alu_cout,

   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_ptr;     // requester favoured on contention
   logic             r_gidx;    // owner of the in-flight operation
   logic [4:0]       r_code;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_coe;
   logic [WIDTH-1:0] r_c;
   logic             r_vout;
   logic             r_cout;
   logic             r_err;

   logic             w_any;
   logic             w_gnt;
   logic             w_accept;
   logic             w_rsp_ready;
   logic             w_legal;
   logic             w_arith;

   function automatic logic f_legal(input logic [4:0] code);
      return code inside {[5'd0:5'd5], 5'd8, 5'd9, 5'd10, 5'd12,
                          [5'd16:5'd19], [5'd24:5'd29]};
   endfunction

   // Grant selection: a lone requester wins, contention follows the pointer.
   always_comb begin
      w_any = req0_valid | req1_valid;
      w_gnt = req1_valid;
      if (req0_valid && req1_valid) w_gnt = r_ptr;
   end

   // rst_n gating keeps both readies low while reset is held, even with
   // valids asserted and the state register already forced to IDLE.
   assign w_accept    = rst_n && (r_state == S_IDLE) && w_any;
   assign w_rsp_ready = r_gidx ? rsp1_ready : rsp0_ready;
   assign w_legal     = f_legal(r_code);
   assign w_arith     = (r_code[4:3] == 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req0_ready  = 1'b0;
      req1_ready  = 1'b0;
      rsp0_valid  = 1'b0;
      rsp1_valid  = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy       = 1'b0;
            req0_ready = w_accept & ~w_gnt;
            req1_ready = w_accept &  w_gnt;
            if (w_accept) w_state_nxt = S_ISSUE;
         end
         S_ISSUE: w_state_nxt = S_RESP;
         S_RESP: begin
            rsp0_valid = ~r_gidx;
            rsp1_valid =  r_gidx;
            if (w_rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Accept: latch the granted operation and hand priority to the other side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr  <= 1'b0;
         r_gidx <= 1'b0;
         r_code <= 5'b00000;
         r_a    <= '0;
         r_b    <= '0;
         r_coe  <= 1'b1;
      end else if (w_accept) begin
         r_ptr  <= ~w_gnt;
         r_gidx <= w_gnt;
         r_code <= w_gnt ? req1_code : req0_code;
         r_a    <= w_gnt ? req1_a    : req0_a;
         r_b    <= w_gnt ? req1_b    : req0_b;
         r_coe  <= w_gnt ? req1_coe  : req0_coe;
      end
   end

   // ISSUE -> RESP: capture the settled ALU output. Flags are only meaningful
   // for the arithmetic group (code[4:3]==00); illegal codes return all zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c    <= '0;
         r_vout <= 1'b0;
         r_cout <= 1'b0;
         r_err  <= 1'b0;
      end else if (r_state == S_ISSUE) begin
         r_c    <= w_legal ? alu_c : '0;
         r_vout <= w_legal & w_arith & alu_vout;
         r_cout <= w_legal & w_arith & alu_cout;
         r_err  <= ~w_legal;
      end
   end

   assign alu_a     = r_a;
   assign alu_b     = r_b;
   assign alu_code  = r_code;
   assign alu_coe   = r_coe;

   assign rsp0_c    = r_c;
   assign rsp0_vout = r_vout;
   assign rsp0_cout = r_cout;
   assign rsp0_err  = r_err;
   assign rsp1_c    = r_c;
   assign rsp1_vout = r_vout;
   assign rsp1_cout = r_cout;
   assign rsp1_err  = r_err;

endmodule
